ras_ckpt_stack: RTL
===================

Name: ras_ckpt_stack

Overview:
Parametrised return-address stack for the frontend branch predictor, generalising the fixed two-entry RAS to any depth and address width. Adds a FIFO of speculation checkpoints so that a branch mispredict can restore the stack pointer and occupancy. Sits between the frontend predictor (push/pop on call/return) and the branch unit and commit stage (checkpoint restore and release).

Parameters:
DEPTH, 2, number of RAS entries; must be at least 2, any integer value.
VLEN, 32, width of a stored return address in bits.
NR_CKPT, 4, number of checkpoint slots; must be a power of two, at least 2.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
flush_i  in  1  empty the RAS and free all checkpoints
push_i  in  1  push push_addr_i (call)
push_addr_i  in  VLEN  return address to push
pop_i  in  1  pop top (return)
top_o  out  VLEN  current top entry
top_valid_o  out  1  RAS occupancy is nonzero
ckpt_save_i  in  1  allocate a checkpoint
ckpt_id_o  out  log2(NR_CKPT)  id that the next save allocates (tail)
ckpt_full_o  out  1  all NR_CKPT slots in use
ckpt_restore_i  in  1  restore the state held in slot ckpt_restore_id_i
ckpt_restore_id_i  in  log2(NR_CKPT)  slot to restore
ckpt_release_i  in  1  free the oldest checkpoint (head)

Behaviour:
- Interface: one clock, clk_i; rst_ni is asynchronous and active-low.
- State:
  - mem[DEPTH], tos pointer (0..DEPTH-1), cnt (0..DEPTH).
  - Checkpoint ring: slot[NR_CKPT] holds {tos, cnt}; head, tail, ccnt (0..NR_CKPT).
- Reset: mem, tos, cnt, head, tail and ccnt all 0. Outputs: top_o=0, top_valid_o=0, ckpt_full_o=0, ckpt_id_o=0.
- Outputs:
  - top_o=mem[tos] and top_valid_o=(cnt!=0), read combinationally from registered state.
  - ckpt_id_o=tail and ckpt_full_o=(ccnt==NR_CKPT).
- Stack updates (all registered, one-cycle latency):
  - push only: tos<=(tos+1) mod DEPTH; mem[new tos]<=push_addr_i; cnt<=min(cnt+1, DEPTH). On overflow the oldest entry is silently overwritten.
  - pop only: if cnt==0, no effect. Otherwise tos<=(tos-1) mod DEPTH and cnt<=cnt-1. The popped entry is not cleared.
  - push and pop together: if cnt!=0, mem[tos]<=push_addr_i with tos and cnt unchanged (replace). If cnt==0, behaves as push only.
- Priority: flush_i > ckpt_restore_i > push/pop. Lower-priority stack ops in the same cycle are dropped.
- Flush: cnt<=0, tos<=0, head<=tail<=0, ccnt<=0. mem is not cleared.
- Checkpoint save:
  - Accepted only when !ckpt_full_o and no flush or restore is active.
  - Stores the post-update {tos, cnt}, i.e. including this cycle's push/pop, into slot[tail]; tail<=tail+1; ccnt<=ccnt+1.
  - Save while full is ignored and the state is unchanged. It is an assertion error in simulation.
- Checkpoint release: if ccnt!=0, head<=head+1 and ccnt<=ccnt-1. Release while empty is ignored.
- Save and release together: both apply; ccnt is unchanged.
- Checkpoint restore:
  - {tos, cnt}<=slot[id].
  - Slot id and every younger slot are freed: tail<=id; ccnt<=(id-head) mod NR_CKPT.
  - A save in the same cycle is dropped.
  - Restore together with release: head advances first. If id==head, the ring becomes empty with head=tail=id+1.
  - Restore of an id not currently allocated is an assertion error; the resulting state is unspecified.
- Entries overwritten by pushes made after a checkpoint are not repaired; the optional feature covers only the top entry.
- Reset asserted mid-operation clears all state immediately, regardless of pending ops.

Optional Feature:
RAS_CKPT_TOP_REPAIR_EN:
- Defined: each slot also stores mem[post-update tos] (VLEN bits). Restore writes that value back into mem[restored tos], so top_o after restore equals the top at save time even if it was overwritten in between.
- Undefined: slots hold only {tos, cnt} and no repair write occurs.

Test Plan:
- DEPTH=4: reset, then push 0x100, 0x200, 0x300 -> top_o=0x300, top_valid_o=1; three pops -> top_valid_o=0; a fourth pop -> tos and cnt unchanged.
- DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50 -> cnt=4, top_o=0x50; four pops return 0x50, 0x40, 0x30, 0x20, then top_valid_o=0.
- Push 0xA, then push+pop of 0xB in the same cycle -> top_o=0xB, cnt=1; push+pop of 0xC on an empty stack -> top_o=0xC, cnt=1.
- Push 0xA, save (id 0), push 0xB, pop, pop, then restore id 0 -> cnt=1 and top_o=0xA; ckpt_id_o=0, ccnt=0.
- Four saves -> ckpt_full_o=1; a fifth save is ignored; one release -> ckpt_full_o=0 and head=1; restore id 2 -> ccnt=1 and tail=2.
- With RAS_CKPT_TOP_REPAIR_EN: push 0xA, save, pop, push 0xF, restore -> top_o=0xA. Without the macro the same sequence gives top_o=0xF.

Source files
------------

// File: rtl/ras_ckpt_stack.sv
// Return-address stack with a FIFO ring of speculation checkpoints holding {tos, cnt}.
// Define RAS_CKPT_TOP_REPAIR_EN to also checkpoint the top entry and write it back on restore.
module ras_ckpt_stack #(
  parameter int DEPTH   = 2,
  parameter int VLEN    = 32,
  parameter int NR_CKPT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [VLEN-1:0]            push_addr_i,
  input  logic                       pop_i,
  output logic [VLEN-1:0]            top_o,
  output logic                       top_valid_o,
  input  logic                       ckpt_save_i,
  output logic [$clog2(NR_CKPT)-1:0] ckpt_id_o,
  output logic                       ckpt_full_o,
  input  logic                       ckpt_restore_i,
  input  logic [$clog2(NR_CKPT)-1:0] ckpt_restore_id_i,
  input  logic                       ckpt_release_i
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int CID_W  = $clog2(NR_CKPT);
  localparam int CCNT_W = CID_W + 1;

  typedef struct packed {
    logic [PTR_W-1:0] tos;
    logic [CNT_W-1:0] cnt;
  } ckpt_t;

  logic [VLEN-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]  r_tos;
  logic [CNT_W-1:0]  r_cnt;
  ckpt_t             r_slot [NR_CKPT];
  logic [CID_W-1:0]  r_head, r_tail;
  logic [CCNT_W-1:0] r_ccnt;

  logic [PTR_W-1:0]  w_tos_inc, w_tos_dec, w_tos_nxt, w_wr_ptr;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_empty, w_wr_en;
  logic              w_save_ok, w_rel_ok;
  logic [CID_W-1:0]  w_head_adv;
  ckpt_t             w_rest_slot;

  assign top_o       = r_mem[r_tos];
  assign top_valid_o = (r_cnt != '0);
  assign ckpt_id_o   = r_tail;
  assign ckpt_full_o = (r_ccnt == CCNT_W'(NR_CKPT));

  // Explicit wrap so DEPTH need not be a power of two.
  assign w_tos_inc = (r_tos == PTR_W'(DEPTH - 1)) ? '0 : r_tos + PTR_W'(1);
  assign w_tos_dec = (r_tos == '0) ? PTR_W'(DEPTH - 1) : r_tos - PTR_W'(1);
  assign w_empty   = (r_cnt == '0);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_tos_nxt = r_tos;
    w_cnt_nxt = r_cnt;
    w_wr_en   = 1'b0;
    w_wr_ptr  = r_tos;
    if (push_i && (!pop_i || w_empty)) begin
      w_tos_nxt = w_tos_inc;
      w_cnt_nxt = (r_cnt == CNT_W'(DEPTH)) ? r_cnt : r_cnt + CNT_W'(1);
      w_wr_en   = 1'b1;
      w_wr_ptr  = w_tos_inc;
    end else if (push_i && pop_i) begin
      w_wr_en   = 1'b1;
    end else if (pop_i && !w_empty) begin
      w_tos_nxt = w_tos_dec;
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  assign w_save_ok   = ckpt_save_i && !ckpt_full_o && !flush_i && !ckpt_restore_i;
  assign w_rel_ok    = ckpt_release_i && (r_ccnt != '0);
  assign w_head_adv  = w_rel_ok ? r_head + CID_W'(1) : r_head;
  assign w_rest_slot = r_slot[ckpt_restore_id_i];

`ifdef RAS_CKPT_TOP_REPAIR_EN
  logic [VLEN-1:0] r_slot_top [NR_CKPT];
  logic [VLEN-1:0] w_top_nxt;
  // Every stack write lands on the post-update tos, so a write this cycle is the new top.
  assign w_top_nxt = w_wr_en ? push_addr_i : r_mem[w_tos_nxt];
`endif

  // NOTE: the stack array is reset so top_o is defined out of reset; checkpoint slots are
  // only read once allocated, so they are plain flops without reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_tos <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_tos <= '0;
      r_cnt <= '0;
    end else if (ckpt_restore_i) begin
      r_tos <= w_rest_slot.tos;
      r_cnt <= w_rest_slot.cnt;
`ifdef RAS_CKPT_TOP_REPAIR_EN
      r_mem[w_rest_slot.tos] <= r_slot_top[ckpt_restore_id_i];
`endif
    end else begin
      r_tos <= w_tos_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_wr_en) r_mem[w_wr_ptr] <= push_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_save_ok) begin
      r_slot[r_tail] <= '{tos: w_tos_nxt, cnt: w_cnt_nxt};
`ifdef RAS_CKPT_TOP_REPAIR_EN
      r_slot_top[r_tail] <= w_top_nxt;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head <= '0;
      r_tail <= '0;
      r_ccnt <= '0;
    end else if (flush_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_ccnt <= '0;
    end else if (ckpt_restore_i) begin
      r_head <= w_head_adv;
      // Releasing the restored slot itself leaves nothing allocated.
      if (w_rel_ok && (ckpt_restore_id_i == r_head)) begin
        r_tail <= w_head_adv;
        r_ccnt <= '0;
      end else begin
        r_tail <= ckpt_restore_id_i;
        r_ccnt <= CCNT_W'(ckpt_restore_id_i - w_head_adv);
      end
    end else begin
      r_head <= w_head_adv;
      if (w_save_ok) r_tail <= r_tail + CID_W'(1);
      case ({w_save_ok, w_rel_ok})
        2'b10:   r_ccnt <= r_ccnt + CCNT_W'(1);
        2'b01:   r_ccnt <= r_ccnt - CCNT_W'(1);
        default: r_ccnt <= r_ccnt;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Reported but not fatal: the hardware ignores the save and carries on.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(ckpt_save_i && ckpt_full_o && !flush_i && !ckpt_restore_i))
        else $warning("ras_ckpt_stack: checkpoint save while ring full ignored");
      assert (!(ckpt_restore_i && !flush_i &&
                (CCNT_W'(ckpt_restore_id_i - r_head) >= r_ccnt)))
        else $warning("ras_ckpt_stack: restore of unallocated checkpoint %0d", ckpt_restore_id_i);
    end
  end
`endif

endmodule
